req_ack_responder: RTL and testbench
====================================

REQ_ACK_RESPONDER -- requirements
Module: req_ack_responder

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of independent req/ack channels (1..16).
REQ-002 SHALL have parameter ACK_LATENCY, default 4: cycles from an accepted req to its ack (1..64).
REQ-003 SHALL have parameter MIN_GAP, default 8: minimum cycles between accepted reqs on one channel; SHALL require MIN_GAP > ACK_LATENCY (elaboration error otherwise).
REQ-004 SHALL have parameter CNT_W, default 32: width of all event counters.
REQ-005 SHALL have port clk  input  1  sole clock; all logic on posedge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port req  input  NUM_CH  per-channel request, single-cycle pulse expected.
REQ-008 SHALL have port ack  output  NUM_CH  per-channel acknowledge, single-cycle pulse, registered.
REQ-009 SHALL have port busy  output  NUM_CH  channel not IDLE.
REQ-010 SHALL have port err_spacing  output  NUM_CH  sticky: req arrived while channel not IDLE.
REQ-011 SHALL have port reqs_seen  output  NUM_CH*CNT_W  per-channel accepted-req count, channel c at bits [c*CNT_W +: CNT_W].
REQ-012 SHALL have port acks_seen  output  NUM_CH*CNT_W  per-channel issued-ack count, same packing.
REQ-013 SHALL have port cycle_count  output  CNT_W  cycles since reset deasserted.

Function
REQ-014 Each channel SHALL run an FSM with states IDLE, WAIT_ACK, COOLDOWN and one down-counter of width $clog2(MIN_GAP+1).
REQ-015 IDLE with req[c] sampled high at edge n: SHALL accept, go WAIT_ACK, load counter ACK_LATENCY-1, increment reqs_seen[c].
REQ-016 WAIT_ACK: counter decrements each edge; at 0 the channel SHALL drive ack[c] high so it is sampled high at edge n+ACK_LATENCY, and go COOLDOWN with counter MIN_GAP-ACK_LATENCY-1.
REQ-017 ack[c] SHALL be high for exactly one cycle per accepted req and never otherwise; acks_seen[c] SHALL increment on the edge after ack[c] is high.
REQ-018 COOLDOWN: counter decrements; at 0 SHALL return to IDLE, so next req is acceptable at edge n+MIN_GAP.
REQ-019 req[c] high in WAIT_ACK or COOLDOWN SHALL be dropped (no count, no ack, no timing change) and SHALL set err_spacing[c], which stays set until rst.
REQ-020 A req held high for k cycles SHALL be accepted once (first cycle) and flag err_spacing for cycles 2..k.
REQ-021 Channels SHALL be fully independent; simultaneous reqs on all channels SHALL each be accepted.
REQ-022 All counters SHALL wrap modulo 2^CNT_W without flag.
REQ-023 cycle_count SHALL increment every non-reset edge, wrapping.
REQ-024 busy[c] SHALL be high exactly in WAIT_ACK and COOLDOWN.

Reset
REQ-025 rst high at an edge SHALL put all channels in IDLE, clear counters, ack, busy, err_spacing, reqs_seen, acks_seen, cycle_count to 0.
REQ-026 rst mid-WAIT_ACK SHALL cancel the pending ack; no ack SHALL appear after reset for a pre-reset req.
REQ-027 req high in the same cycle as rst SHALL be ignored; first acceptable req is at the first edge with rst low.

Structure
REQ-028 A shared package req_ack_pkg SHALL hold the channel state enum (IDLE, WAIT_ACK, COOLDOWN) and default parameter constants.
REQ-029 Per-channel FSM, counter and per-channel counters SHALL be a sub-module req_ack_channel, instantiated NUM_CH times by generate; top holds cycle_count only.
REQ-030 Formal build SHALL bind properties: req |-> ##ACK_LATENCY ack when accepted; !accepted-req ACK_LATENCY ago |-> !ack; acks_seen <= reqs_seen.

Verification (NUM_CH=2, ACK_LATENCY=4, MIN_GAP=8)
REQ-031 req[0] pulse at edge 10 -> ack[0] sampled high at edge 14 only; reqs_seen[0]=1, acks_seen[0]=1 by edge 15; channel 1 untouched.
REQ-032 req[0] at edges 10 and 18 -> acks at 14 and 22, err_spacing[0]=0; req[0] at edges 10 and 17 -> one ack at 14, err_spacing[0]=1, reqs_seen[0]=1.
REQ-033 req[0] high edges 10..12 -> single ack at 14, reqs_seen[0]=1, err_spacing[0]=1.
REQ-034 req=2'b11 at edge 5 -> ack=2'b11 at edge 9; both counts 1.
REQ-035 req[1] at edge 10, rst at edge 12 -> no ack at 14, all outputs 0 at edge 13; req[1] at edge 13 -> ack at 17.
REQ-036 CNT_W=4, 17 legally spaced reqs on channel 0 -> reqs_seen[0]=1 and acks_seen[0]=1 after wrap.

Source files
------------

// File: rtl/req_ack_pkg.sv
// Shared definitions for the req/ack responder.
//   chan_state_e : per-channel FSM state (IDLE, WAIT_ACK, COOLDOWN)
//   DEF_*        : default values for the responder parameters
package req_ack_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        COOLDOWN = 2'd2
    } chan_state_e;

    localparam int DEF_NUM_CH      = 2;
    localparam int DEF_ACK_LATENCY = 4;
    localparam int DEF_MIN_GAP     = 8;
    localparam int DEF_CNT_W       = 32;

endpackage

// File: rtl/req_ack_channel.sv
// One independent req/ack channel.
// Handshake: a req sampled high while the channel can accept is taken once;
// ack is a registered single-cycle pulse sampled high exactly ACK_LATENCY
// edges after the accepting edge; the next req is acceptable MIN_GAP edges
// after the accepting edge. reqs arriving earlier are dropped and flagged.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   req         : request pulse
//   ack         : acknowledge pulse (registered)
//   state       : current FSM state (busy/debug observation)
//   err_spacing : sticky, a req arrived while the channel was not accepting
//   reqs_seen   : accepted-req count (wraps)
//   acks_seen   : issued-ack count (wraps)
module req_ack_channel
    import req_ack_pkg::*;
#(
    parameter int ACK_LATENCY = DEF_ACK_LATENCY,
    parameter int MIN_GAP     = DEF_MIN_GAP,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    output logic             ack,
    output chan_state_e      state,
    output logic             err_spacing,
    output logic [CNT_W-1:0] reqs_seen,
    output logic [CNT_W-1:0] acks_seen
);

    localparam int CW = $clog2(MIN_GAP + 1);
    localparam logic [CW-1:0] LAT_LOAD  = CW'(ACK_LATENCY - 1);
    localparam logic [CW-1:0] COOL_LOAD = CW'(MIN_GAP - ACK_LATENCY - 1);

    if (MIN_GAP <= ACK_LATENCY) begin : g_bad_gap
        $error("req_ack_channel: MIN_GAP must exceed ACK_LATENCY");
    end
    if (ACK_LATENCY < 1 || ACK_LATENCY > 64) begin : g_bad_lat
        $error("req_ack_channel: ACK_LATENCY must be 1..64");
    end

    chan_state_e      state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ack_q, ack_d;
    logic             err_q;
    logic [CNT_W-1:0] reqs_q, acks_q;
    logic             accept, drop;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        drop    = 1'b0;
        case (state_q)
            IDLE: begin
                accept = req;
            end
            WAIT_ACK: begin
                drop = req;
                if (cnt_q == '0) begin
                    state_d = COOLDOWN;
                    cnt_d   = COOL_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            COOLDOWN: begin
                // The last cooldown cycle is also the first cycle at which a
                // new req is legal, so it accepts directly instead of
                // spending an extra cycle in IDLE.
                if (cnt_q == '0) begin
                    accept  = req;
                    state_d = IDLE;
                end else begin
                    drop  = req;
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            state_d = WAIT_ACK;
            cnt_d   = LAT_LOAD;
        end
        // Register the ack so it is high in the cycle where WAIT_ACK holds 0.
        ack_d = (state_d == WAIT_ACK) && (cnt_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            reqs_q  <= '0;
            acks_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            err_q   <= err_q | drop;
            reqs_q  <= reqs_q + CNT_W'(accept);
            acks_q  <= acks_q + CNT_W'(ack_q);
        end
    end

    assign ack         = ack_q;
    assign state       = state_q;
    assign err_spacing = err_q;
    assign reqs_seen   = reqs_q;
    assign acks_seen   = acks_q;

`ifdef FORMAL
    a_ack_after_accept : assert property (@(posedge clk) disable iff (rst)
        accept |-> ##ACK_LATENCY ack_q);
    a_no_spurious_ack : assert property (@(posedge clk) disable iff (rst)
        !$past(accept, ACK_LATENCY) |-> !ack_q);
    // With at most one req outstanding, acks trail reqs by zero or one
    // (modulo the counter width).
    a_acks_le_reqs : assert property (@(posedge clk) disable iff (rst)
        (acks_q == reqs_q) || (acks_q + CNT_W'(1) == reqs_q));
`endif

endmodule

// File: rtl/req_ack_responder.sv
// Multi-channel req/ack responder: NUM_CH independent channels, each
// answering an accepted req with a single ack pulse ACK_LATENCY edges later.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   req          : per-channel request pulses
//   ack          : per-channel acknowledge pulses
//   busy         : channel is in WAIT_ACK or COOLDOWN
//   err_spacing  : sticky per-channel early-req flag
//   reqs_seen    : per-channel accepted-req counts, channel c at [c*CNT_W +: CNT_W]
//   acks_seen    : per-channel issued-ack counts, same packing
//   cycle_count  : edges since reset deasserted (wraps)
module req_ack_responder
    import req_ack_pkg::*;
#(
    parameter int NUM_CH      = DEF_NUM_CH,
    parameter int ACK_LATENCY = DEF_ACK_LATENCY,
    parameter int MIN_GAP     = DEF_MIN_GAP,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       req,
    output logic [NUM_CH-1:0]       ack,
    output logic [NUM_CH-1:0]       busy,
    output logic [NUM_CH-1:0]       err_spacing,
    output logic [NUM_CH*CNT_W-1:0] reqs_seen,
    output logic [NUM_CH*CNT_W-1:0] acks_seen,
    output logic [CNT_W-1:0]        cycle_count
);

    if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_ch
        $error("req_ack_responder: NUM_CH must be 1..16");
    end

    chan_state_e ch_state [NUM_CH];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        req_ack_channel #(
            .ACK_LATENCY (ACK_LATENCY),
            .MIN_GAP     (MIN_GAP),
            .CNT_W       (CNT_W)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .req         (req[c]),
            .ack         (ack[c]),
            .state       (ch_state[c]),
            .err_spacing (err_spacing[c]),
            .reqs_seen   (reqs_seen[c*CNT_W +: CNT_W]),
            .acks_seen   (acks_seen[c*CNT_W +: CNT_W])
        );
        assign busy[c] = (ch_state[c] != IDLE);
    end

    logic [CNT_W-1:0] cycle_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_q + CNT_W'(1);
        end
    end

    assign cycle_count = cycle_q;

endmodule

// File: tb/tb_req_ack_responder.sv
// Bench for req_ack_responder. A timing-rule model (accept when at least
// MIN_GAP edges have passed since the last accept, ack ACK_LATENCY edges
// later) predicts every ack into an expected queue; a negedge monitor pops
// and compares whenever the DUT presents ack, and checks the counters,
// flags and busy against the model every cycle.
module tb_req_ack_responder;

    localparam int NUM_CH = 2;
    localparam int L      = 4;
    localparam int G      = 8;
    localparam int CNT_W  = 4;
    localparam int W      = 40;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NUM_CH-1:0]       req;
    logic [NUM_CH-1:0]       ack;
    logic [NUM_CH-1:0]       busy;
    logic [NUM_CH-1:0]       err_spacing;
    logic [NUM_CH*CNT_W-1:0] reqs_seen;
    logic [NUM_CH*CNT_W-1:0] acks_seen;
    logic [CNT_W-1:0]        cycle_count;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    req_ack_responder #(
        .NUM_CH      (NUM_CH),
        .ACK_LATENCY (L),
        .MIN_GAP     (G),
        .CNT_W       (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .ack         (ack),
        .busy        (busy),
        .err_spacing (err_spacing),
        .reqs_seen   (reqs_seen),
        .acks_seen   (acks_seen),
        .cycle_count (cycle_count)
    );

    // ---------------- scoreboard state ----------------
    int compared = 0;
    int failed   = 0;
    int edge_n   = 0;
    bit mon_en   = 1'b0;

    logic [W-1:0] exp_q[$];   // {channel[39:32], ack sample edge[31:0]}

    bit               has_acc [NUM_CH];
    int               last_acc[NUM_CH];
    logic [CNT_W-1:0] n_acc   [NUM_CH];
    logic [CNT_W-1:0] n_ack   [NUM_CH];
    bit               err_m   [NUM_CH];
    logic [CNT_W-1:0] cc_m;

    task automatic check(input string name, input int ch,
                         input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s ch=%0d edge=%0d got=%0h expected=%0h",
                     name, ch, edge_n + 1, act, exp);
        end
    endtask

    // ---------------- reference model (updated at each edge) ----------------
    always @(posedge clk) begin
        logic [W-1:0] keep[$];
        edge_n = edge_n + 1;
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                has_acc[c] = 1'b0;
                last_acc[c] = 0;
                n_acc[c] = '0;
                n_ack[c] = '0;
                err_m[c] = 1'b0;
            end
            cc_m = '0;
            // Acks that would be sampled after this edge are cancelled.
            keep = {};
            for (int i = 0; i < exp_q.size(); i++)
                if (int'(exp_q[i][31:0]) <= edge_n) keep.push_back(exp_q[i]);
            exp_q = keep;
            mon_en = 1'b1;
        end else if (mon_en) begin
            cc_m = cc_m + 1'b1;
            for (int c = 0; c < NUM_CH; c++) begin
                if (has_acc[c] && edge_n == last_acc[c] + L)
                    n_ack[c] = n_ack[c] + 1'b1;
                if (req[c]) begin
                    if (!has_acc[c] || edge_n >= last_acc[c] + G) begin
                        has_acc[c] = 1'b1;
                        last_acc[c] = edge_n;
                        n_acc[c] = n_acc[c] + 1'b1;
                        exp_q.push_back({8'(c), 32'(edge_n + L)});
                    end else begin
                        err_m[c] = 1'b1;
                    end
                end
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            int s;
            bit exp_ack;
            s = edge_n + 1;
            for (int c = 0; c < NUM_CH; c++) begin
                exp_ack = (exp_q.size() > 0) && (exp_q[0] == {8'(c), 32'(s)});
                check("ack", c, 32'(ack[c]), 32'(exp_ack));
                if (exp_ack) void'(exp_q.pop_front());
                check("reqs_seen", c, 32'(reqs_seen[c*CNT_W +: CNT_W]), 32'(n_acc[c]));
                check("acks_seen", c, 32'(acks_seen[c*CNT_W +: CNT_W]), 32'(n_ack[c]));
                check("err_spacing", c, 32'(err_spacing[c]), 32'(err_m[c]));
                check("busy", c, 32'(busy[c]),
                      32'(has_acc[c] && (s <= last_acc[c] + G)));
            end
            check("cycle_count", 0, 32'(cycle_count), 32'(cc_m));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input logic [NUM_CH-1:0] r, input logic x);
        req = r;
        rst = x;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [NUM_CH-1:0] r, prev;
        logic x;
        req = '0;
        rst = 1'b1;
        step('0, 1'b1);
        step('0, 1'b1);
        idle(5);

        // Single pulse on channel 0.
        step(2'b01, 1'b0); idle(12);
        // Legal spacing of exactly MIN_GAP.
        step(2'b01, 1'b0); idle(G - 1); step(2'b01, 1'b0); idle(12);
        // One cycle too early: dropped and flagged.
        step(2'b01, 1'b0); idle(G - 2); step(2'b01, 1'b0); idle(12);
        // Held req: accepted once.
        step(2'b01, 1'b0); step(2'b01, 1'b0); step(2'b01, 1'b0); idle(12);
        // Both channels at once.
        step(2'b11, 1'b0); idle(12);
        // Reset while channel 1 waits for its ack, then req right after reset.
        step(2'b10, 1'b0); step('0, 1'b0); step('0, 1'b1);
        step(2'b10, 1'b0); idle(12);
        // Req together with reset is ignored.
        step(2'b11, 1'b1); idle(12);

        // Seventeen legally spaced reqs wrap the 4-bit counters to 1.
        step('0, 1'b1);
        for (int i = 0; i < 17; i++) begin
            step(2'b01, 1'b0);
            idle(G - 1);
        end
        idle(10);
        @(negedge clk);
        check("wrap_reqs", 0, 32'(reqs_seen[CNT_W-1:0]), 32'd1);
        check("wrap_acks", 0, 32'(acks_seen[CNT_W-1:0]), 32'd1);
        #1;

        // Random traffic with held reqs and occasional resets.
        prev = '0;
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < NUM_CH; c++)
                r[c] = (prev[c] && $urandom_range(0, 2) == 0) ||
                       ($urandom_range(0, 7) == 0);
            x = ($urandom_range(0, 199) == 0);
            step(r, x);
            prev = r;
        end
        idle(20);

        @(negedge clk);
        check("queue_empty", 0, 32'(exp_q.size()), 32'd0);
        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
